// File: rtl/write_release_mc_pkg.sv
// Shared types and helpers for the multi-channel write-release unit:
// FSM state encoding, FIFO-word layout and saturating counter arithmetic.
package write_release_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    READ_FIFO    = 3'd1,
    PARSE        = 3'd2,
    FILTER       = 3'd3,
    WRITE_UPDATE = 3'd4,
    WRITE_WAIT   = 3'd5,
    RELEASE      = 3'd6
  } wr_state_e;

  localparam int unsigned ADDR_W  = 31;
  localparam int unsigned CNT_W   = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = 32'hFFFF_FFFF;

  // Index width that stays legal for a single channel.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // FIFO word is {filter_bit, entry}.
  function automatic int unsigned fifo_word_w(input int unsigned data_w);
    return data_w + 32'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/write_release_mc_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last winner,
// wrapping; the pointer only moves when the caller accepts the grant.
module rr_arbiter
  import write_release_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_advance,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] r_ptr;
  logic [31:0]      w_cand;
  logic [IDX_W-1:0] w_cand_idx;
  logic             w_hit;

  // Scan N slots starting just after the pointer and keep the first hit.
  always_comb begin
    o_grant    = '0;
    o_idx      = '0;
    o_valid    = 1'b0;
    w_cand     = 32'd0;
    w_cand_idx = '0;
    w_hit      = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand     = ((32'(r_ptr) + k) >= N) ? (32'(r_ptr) + k - N) : (32'(r_ptr) + k);
      w_cand_idx = IDX_W'(w_cand);
      w_hit      = i_req[w_cand_idx] & ~o_valid;
      o_grant[w_cand_idx] = o_grant[w_cand_idx] | w_hit;
      o_idx      = w_hit ? w_cand_idx : o_idx;
      o_valid    = o_valid | w_hit;
    end
  end

  // Pointer holds the last winner; reset value N-1 makes channel 0 win first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= IDX_W'(N - 1);
    end else if (i_advance && o_valid) begin
      r_ptr <= o_idx;
    end
  end

endmodule

// File: rtl/write_release_mc.sv
// Multi-channel write-release unit: drains compute write FIFOs round-robin,
// writes unfiltered entries to DDR at base+hash(key), then releases the key.
module write_release_mc
  import write_release_pkg::*;
#(
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned DATA_W           = 256,
  parameter int unsigned KEY_W            = 32,
  parameter int unsigned DDR_BASE         = 0,
  parameter int unsigned ENTRY_BYTES_LOG2 = 5,
  parameter int unsigned WR_LENGTH        = 32,
  parameter bit          RELEASE_ACK_EN   = 1'b1
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic [NUM_CH*fifo_word_w(DATA_W)-1:0] i_compute_write_fifo_q,
  input  logic [NUM_CH-1:0]                   i_compute_write_fifo_empty,
  output logic [NUM_CH-1:0]                   o_compute_write_fifo_rdreq,
  output logic                                o_wr_control_fixed_location,
  output logic [ADDR_W-1:0]                   o_wr_control_write_base,
  output logic [ADDR_W-1:0]                   o_wr_control_write_length,
  output logic                                o_wr_control_go,
  input  logic                                i_wr_control_done,
  output logic                                o_wr_user_write_buffer,
  output logic [DATA_W-1:0]                   o_wr_user_buffer_data,
  input  logic                                i_wr_user_buffer_full,
  input  logic [31:0]                         i_log_2_num_workers_in,
  output logic [NUM_CH-1:0]                   o_proc_key_release,
  input  logic [NUM_CH-1:0]                   i_proc_key_release_ack,
  output logic [CNT_W-1:0]                    o_filt_entries,
  output logic [CNT_W-1:0]                    o_write_count
);

  localparam int unsigned WORD_W = fifo_word_w(DATA_W);
  localparam int unsigned IDX_W  = idx_width(NUM_CH);

  wr_state_e          r_state;
  logic [IDX_W-1:0]   r_ch;
  logic               r_filter;
  logic [DATA_W-1:0]  r_entry;
  logic [KEY_W-1:0]   r_key;
  logic               r_done_seen;
  logic [NUM_CH-1:0]  r_rdreq;
  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W-1:0]  r_length;
  logic               r_go;
  logic               r_push;
  logic [DATA_W-1:0]  r_data;
  logic [NUM_CH-1:0]  r_release;
  logic [CNT_W-1:0]   r_filt;
  logic [CNT_W-1:0]   r_wcount;

  logic [NUM_CH-1:0]  w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_valid;
  logic               w_advance;
  logic [WORD_W-1:0]  w_word;
  logic [KEY_W-1:0]   w_shifted;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_ack;

  assign w_advance = (r_state == IDLE);

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_reset),
    .i_req     (~i_compute_write_fifo_empty),
    .i_advance (w_advance),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_valid   (w_valid)
  );

  assign w_word = i_compute_write_fifo_q[32'(r_ch)*WORD_W +: WORD_W];
  assign w_ack  = i_proc_key_release_ack[r_ch];

  // Oversized shift amounts collapse the hash to slot 0 rather than wrapping.
  assign w_shifted = (i_log_2_num_workers_in >= 32'(KEY_W)) ? '0 : (r_key >> i_log_2_num_workers_in);
  assign w_addr    = ADDR_W'(DDR_BASE) + (ADDR_W'(w_shifted) << ENTRY_BYTES_LOG2);

  // Main FSM with all handshake outputs and counters registered.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_ch        <= '0;
      r_filter    <= 1'b0;
      r_entry     <= '0;
      r_key       <= '0;
      r_done_seen <= 1'b0;
      r_rdreq     <= '0;
      r_base      <= '0;
      r_length    <= '0;
      r_go        <= 1'b0;
      r_push      <= 1'b0;
      r_data      <= '0;
      r_release   <= '0;
      r_filt      <= '0;
      r_wcount    <= '0;
    end else begin
      r_rdreq <= '0;
      r_go    <= 1'b0;
      r_push  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_release <= '0;
          if (w_valid) begin
            r_rdreq <= w_grant;
            r_ch    <= w_idx;
            r_state <= READ_FIFO;
          end
        end
        READ_FIFO: r_state <= PARSE;
        PARSE: begin
          r_filter <= w_word[DATA_W];
          r_entry  <= w_word[DATA_W-1:0];
          r_key    <= w_word[KEY_W-1:0];
          r_state  <= FILTER;
        end
        FILTER: begin
          if (r_filter) begin
            r_filt  <= sat_inc(r_filt);
            r_state <= RELEASE;
          end else begin
            r_base   <= w_addr;
            r_length <= ADDR_W'(WR_LENGTH);
            r_data   <= r_entry;
            r_go     <= 1'b1;
            r_state  <= WRITE_UPDATE;
          end
        end
        WRITE_UPDATE: begin
          // The master may finish before the data push; remember that.
          if (i_wr_control_done) r_done_seen <= 1'b1;
          if (!i_wr_user_buffer_full) begin
            r_push  <= 1'b1;
            r_state <= WRITE_WAIT;
          end
        end
        WRITE_WAIT: begin
          if (i_wr_control_done || r_done_seen) begin
            r_wcount    <= sat_inc(r_wcount);
            r_done_seen <= 1'b0;
            r_state     <= RELEASE;
          end
        end
        RELEASE: begin
          if (!RELEASE_ACK_EN) begin
            r_release <= NUM_CH'(1) << r_ch;
            r_state   <= IDLE;
          end else if (r_release == '0) begin
            r_release <= NUM_CH'(1) << r_ch;
          end else if (w_ack) begin
            r_release <= '0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_compute_write_fifo_rdreq  = r_rdreq;
  assign o_wr_control_fixed_location = 1'b0;
  assign o_wr_control_write_base     = r_base;
  assign o_wr_control_write_length   = r_length;
  assign o_wr_control_go             = r_go;
  assign o_wr_user_write_buffer      = r_push;
  assign o_wr_user_buffer_data       = r_data;
  assign o_proc_key_release          = r_release;
  assign o_filt_entries              = r_filt;
  assign o_write_count               = r_wcount;

endmodule

// File: tb/tb_write_release_mc.sv
// Directed bench for write_release_mc: a pulse-release instance with a small
// FIFO model drives the main flows, an ack-release instance covers the handshake.
module tb_write_release_mc;

  localparam int NCH = 4;
  localparam int DW  = 256;
  localparam int WW  = DW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pulse-release instance (DDR_BASE 0x1000) signals.
  logic [WW-1:0]     word [NCH];
  int                fifo_tot [NCH];
  int                fifo_rd  [NCH];
  logic [NCH*WW-1:0] a_q;
  logic [NCH-1:0]    a_empty, a_rdreq, a_rel, a_ack;
  logic              a_fixed, a_go, a_done, a_push, a_full;
  logic [30:0]       a_base, a_len;
  logic [DW-1:0]     a_data;
  logic [31:0]       log2w, a_filt, a_wcnt;

  // Ack-release instance signals.
  logic [WW-1:0]     b_word;
  logic [NCH*WW-1:0] b_q;
  logic [NCH-1:0]    b_empty, b_rdreq, b_rel, b_ack;
  logic              b_fixed, b_go, b_push;
  logic [30:0]       b_base, b_len;
  logic [DW-1:0]     b_data;
  logic [31:0]       b_filt, b_wcnt;

  // Monitor state.
  int          rel_cnt [NCH];
  int          go_cnt = 0, push_cnt = 0, order_n = 0, multi_hot = 0;
  int          b_rel_hi = 0, b_rel3 = 0;
  logic [31:0] order_log = 32'h0;

  assign a_q = {word[3], word[2], word[1], word[0]};
  assign b_q = {4{b_word}};
  for (genvar g = 0; g < NCH; g++) begin : g_empty
    assign a_empty[g] = (fifo_rd[g] >= fifo_tot[g]);
  end

  write_release_mc #(.DDR_BASE(32'h1000), .RELEASE_ACK_EN(1'b0)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_compute_write_fifo_q(a_q), .i_compute_write_fifo_empty(a_empty),
    .o_compute_write_fifo_rdreq(a_rdreq),
    .o_wr_control_fixed_location(a_fixed), .o_wr_control_write_base(a_base),
    .o_wr_control_write_length(a_len), .o_wr_control_go(a_go),
    .i_wr_control_done(a_done), .o_wr_user_write_buffer(a_push),
    .o_wr_user_buffer_data(a_data), .i_wr_user_buffer_full(a_full),
    .i_log_2_num_workers_in(log2w), .o_proc_key_release(a_rel),
    .i_proc_key_release_ack(a_ack), .o_filt_entries(a_filt), .o_write_count(a_wcnt)
  );

  write_release_mc #(.RELEASE_ACK_EN(1'b1)) dut_ack (
    .i_clk(clk), .i_reset(rst),
    .i_compute_write_fifo_q(b_q), .i_compute_write_fifo_empty(b_empty),
    .o_compute_write_fifo_rdreq(b_rdreq),
    .o_wr_control_fixed_location(b_fixed), .o_wr_control_write_base(b_base),
    .o_wr_control_write_length(b_len), .o_wr_control_go(b_go),
    .i_wr_control_done(1'b0), .o_wr_user_write_buffer(b_push),
    .o_wr_user_buffer_data(b_data), .i_wr_user_buffer_full(1'b0),
    .i_log_2_num_workers_in(log2w), .o_proc_key_release(b_rel),
    .i_proc_key_release_ack(b_ack), .o_filt_entries(b_filt), .o_write_count(b_wcnt)
  );

  // FIFO read model plus event counters, sampling pre-edge output values.
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (a_rdreq[c]) begin
        fifo_rd[c] <= fifo_rd[c] + 1;
        order_log  <= {order_log[27:0], 4'(c)};
        order_n    <= order_n + 1;
      end
      if (a_rel[c]) rel_cnt[c] <= rel_cnt[c] + 1;
    end
    if (a_go)   go_cnt   <= go_cnt + 1;
    if (a_push) push_cnt <= push_cnt + 1;
    if ($countones({a_rdreq, a_rel, a_go}) > 1) multi_hot <= multi_hot + 1;
    if ($countones({b_rdreq, b_rel, b_go}) > 1) multi_hot <= multi_hot + 1;
    if (b_rel[0]) b_rel_hi <= b_rel_hi + 1;
    if (b_rel[3]) b_rel3   <= b_rel3 + 1;
  end

  function automatic logic [WW-1:0] mk(input logic f, input logic [31:0] key);
    return {f, {7{~key}}, key};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int n0, rel2_before;

  initial begin
    rst = 1'b1; a_done = 1'b0; a_full = 1'b0; a_ack = '0; log2w = 32'd1;
    b_empty = 4'b1111; b_ack = '0; b_word = mk(1'b1, 32'h55);
    for (int c = 0; c < NCH; c++) word[c] = '0;
    tick(3);

    // Reset state.
    chk("rst_rdreq", 64'(a_rdreq), 64'h0);
    chk("rst_rel",   64'(a_rel),   64'h0);
    chk("rst_go",    64'(a_go),    64'h0);
    chk("rst_push",  64'(a_push),  64'h0);
    chk("rst_base",  64'(a_base),  64'h0);
    chk("rst_len",   64'(a_len),   64'h0);
    chk("rst_cnts",  {a_filt, a_wcnt}, 64'h0);
    chk("rst_fixed", 64'(a_fixed), 64'h0);
    rst = 1'b0;

    // All four channels busy with filtered entries: strict rotation from ch0.
    for (int c = 0; c < NCH; c++) begin
      word[c] = mk(1'b1, 32'h100 + 32'(c));
      fifo_tot[c] = 2;
    end
    n0 = order_n;
    for (int i = 0; i < 200; i++) begin
      if (rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] >= 8) break;
      tick(1);
    end
    tick(2);
    chk("rr_reads", 64'(order_n - n0), 64'd8);
    chk("rr_order", 64'(order_log), 64'h0123_0123);
    for (int c = 0; c < NCH; c++) chk("rr_rel_per_ch", 64'(rel_cnt[c]), 64'd2);
    chk("rr_filt",  64'(a_filt), 64'd8);
    chk("rr_no_go", 64'(go_cnt), 64'd0);

    // Unfiltered entry on ch2, key 0x45, log2w 1 -> 0x1000 + 0x440.
    word[2] = mk(1'b0, 32'h45);
    fifo_tot[2] = 3;
    for (int i = 0; i < 30; i++) begin if (a_go) break; tick(1); end
    chk("t1_go",      64'(a_go),   64'd1);
    chk("t1_base",    64'(a_base), 64'h1440);
    chk("t1_len",     64'(a_len),  64'd32);
    chk("t1_data_lo", a_data[63:0],    64'hFFFF_FFBA_0000_0045);
    chk("t1_data_hi", a_data[255:192], 64'hFFFF_FFBA_FFFF_FFBA);
    tick(1);
    chk("t1_push", 64'(a_push), 64'd1);
    a_done = 1'b1; tick(1); a_done = 1'b0;
    for (int i = 0; i < 20; i++) begin if (a_rel != '0) break; tick(1); end
    chk("t1_rel", 64'(a_rel), 64'h4);
    tick(1);
    chk("t1_rel_one_cycle", 64'(a_rel), 64'h0);
    chk("t1_wcnt", 64'(a_wcnt), 64'd1);
    chk("t1_go_pulses", 64'(go_cnt), 64'd1);
    chk("t1_pushes", 64'(push_cnt), 64'd1);

    // Three filtered entries on ch1; first release exactly 4 cycles after rdreq.
    word[1] = mk(1'b1, 32'h77);
    fifo_tot[1] = 5;
    for (int i = 0; i < 20; i++) begin if (a_rdreq[1]) break; tick(1); end
    tick(4);
    chk("t3_latency", 64'(a_rel), 64'h2);
    for (int i = 0; i < 100; i++) begin if (rel_cnt[1] >= 5) break; tick(1); end
    tick(2);
    chk("t3_filt",  64'(a_filt),     64'd11);
    chk("t3_rel",   64'(rel_cnt[1]), 64'd5);
    chk("t3_no_go", 64'(go_cnt),     64'd1);

    // done while idle is ignored.
    a_done = 1'b1; tick(2); a_done = 1'b0; tick(1);
    chk("idle_done", 64'(a_wcnt), 64'd1);

    // Buffer full for ~20 cycles with done arriving during WRITE_UPDATE.
    log2w = 32'd4; a_full = 1'b1;
    word[0] = mk(1'b0, 32'h1234);
    fifo_tot[0] = 3;
    for (int i = 0; i < 30; i++) begin if (a_go) break; tick(1); end
    chk("t4_base", 64'(a_base), 64'h3460);
    tick(2);
    a_done = 1'b1; tick(1); a_done = 1'b0;
    tick(17);
    chk("t4_no_push", 64'(push_cnt), 64'd1);
    chk("t4_no_rel",  64'(a_rel),    64'h0);
    a_full = 1'b0;
    for (int i = 0; i < 5; i++) begin if (a_push) break; tick(1); end
    chk("t4_push", 64'(a_push), 64'd1);
    for (int i = 0; i < 10; i++) begin if (a_rel != '0) break; tick(1); end
    chk("t4_rel",  64'(a_rel),  64'h1);
    chk("t4_wcnt", 64'(a_wcnt), 64'd2);

    // Shift amount >= KEY_W lands on DDR_BASE.
    log2w = 32'd32;
    word[3] = mk(1'b0, 32'hFFFF_FFFF);
    fifo_tot[3] = 3;
    for (int i = 0; i < 30; i++) begin if (a_go) break; tick(1); end
    chk("shift_base", 64'(a_base), 64'h1000);
    tick(1);
    a_done = 1'b1; tick(1); a_done = 1'b0;
    for (int i = 0; i < 20; i++) begin if (a_rel != '0) break; tick(1); end
    chk("shift_rel",  64'(a_rel),  64'h8);
    chk("shift_wcnt", 64'(a_wcnt), 64'd3);

    // Reset while waiting for done: entry dropped, outputs clear at once.
    log2w = 32'd1;
    word[2] = mk(1'b0, 32'h45);
    fifo_tot[2] = 4;
    for (int i = 0; i < 30; i++) begin if (a_push) break; tick(1); end
    tick(2);
    rel2_before = rel_cnt[2];
    #2 rst = 1'b1;
    #1;
    chk("t6_base", 64'(a_base), 64'h0);
    chk("t6_cnts", {a_filt, a_wcnt}, 64'h0);
    chk("t6_data", a_data[63:0], 64'h0);
    tick(2);
    rst = 1'b0;
    word[0] = mk(1'b1, 32'h9);
    word[3] = mk(1'b1, 32'hA);
    fifo_tot[0] = 4; fifo_tot[3] = 4;
    for (int i = 0; i < 20; i++) begin if (a_rdreq != '0) break; tick(1); end
    chk("t6_first_grant", 64'(a_rdreq), 64'h1);
    for (int i = 0; i < 60; i++) begin if (rel_cnt[3] >= 4) break; tick(1); end
    tick(2);
    chk("t6_no_rel_ch2", 64'(rel_cnt[2]), 64'(rel2_before));
    chk("t6_filt", 64'(a_filt), 64'd2);

    // Ack-release instance: release held until ack[0], spurious ack[3] ignored.
    b_empty = 4'b1110;
    for (int i = 0; i < 20; i++) begin if (b_rdreq[0]) break; tick(1); end
    b_empty = 4'b1111;
    for (int i = 0; i < 20; i++) begin if (b_rel[0]) break; tick(1); end
    chk("t5_rel", 64'(b_rel), 64'h1);
    b_ack = 4'b1000;
    tick(10);
    chk("t5_held", 64'(b_rel), 64'h1);
    b_ack = 4'b1001;
    tick(1);
    b_ack = 4'b0000;
    chk("t5_dropped", 64'(b_rel),  64'h0);
    chk("t5_hi_len",  64'(b_rel_hi), 64'd11);
    chk("t5_no_ch3",  64'(b_rel3),   64'd0);
    chk("t5_filt",    64'(b_filt),   64'd1);

    chk("one_hot_strobes", 64'(multi_hot), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
